// File: rtl/sprite_ram_loader.sv
// ============================================================================
// sprite_ram_loader : unpacks two-pixel source words into a sprite RAM
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module sprite_ram_loader #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH:0]     len,
  input  logic                    s_valid,
  input  logic [2*DATA_WIDTH-1:0] s_data,
  output logic                    s_ready,
  output logic                    we,
  output logic [ADDR_WIDTH-1:0]   addr_w,
  output logic [DATA_WIDTH-1:0]   din,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_LO = 2'd1,
    LOAD_HI = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]     rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic                    done_q, done_d;
  logic                    s_ready_q, s_ready_d;
  logic                    busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    hold_d  = hold_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            ptr_d   = base_addr;
            // Lengths beyond the RAM depth are clamped to one full pass
            rem_d   = (len > MAX_LEN) ? MAX_LEN : len;
            state_d = LOAD_LO;
          end
        end
      end

      LOAD_LO: begin
        if (abort) begin
          state_d = IDLE;
        end else if (s_valid) begin
          we_d   = 1'b1;
          addr_d = ptr_q;
          din_d  = s_data[DATA_WIDTH-1:0];
          hold_d = s_data[2*DATA_WIDTH-1:DATA_WIDTH];
          ptr_d  = ptr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == ONE) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD_HI;
          end
        end
      end

      LOAD_HI: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          we_d   = 1'b1;
          addr_d = ptr_q;
          din_d  = hold_q;
          ptr_d  = ptr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == ONE) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD_LO;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they track state_q exactly
    s_ready_d = (state_d == LOAD_LO);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      hold_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      done_q    <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      hold_q    <= hold_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      done_q    <= done_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
    end
  end

  assign s_ready = s_ready_q;
  assign we      = we_q;
  assign addr_w  = addr_q;
  assign din     = din_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_ram_loader.sv
// ============================================================================
// tb_sprite_ram_loader : directed and randomized check of sprite_ram_loader
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_sprite_ram_loader;

  localparam int DW    = 12;
  localparam int AW    = 10;
  localparam int WW    = 2 * DW;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          s_valid;
  logic [WW-1:0] s_data;
  logic          s_ready;
  logic          we;
  logic [AW-1:0] addr_w;
  logic [DW-1:0] din;
  logic          busy;
  logic          done;

  sprite_ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .base_addr(base_addr),
    .len      (len),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .we       (we),
    .addr_w   (addr_w),
    .din      (din),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [31:0]   c;
  } wr_t;

  wr_t           wq[$];
  int            done_cyc[$];
  logic [WW-1:0] words[$];

  // Observed RAM writes and done pulses, stamped with the cycle they appear in
  always @(negedge clk) begin
    if (we === 1'b1) wq.push_back('{a: addr_w, d: din, c: 32'(cyc)});
    if (done === 1'b1) done_cyc.push_back(cyc);
  end

  function automatic bit chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    return (obs === exp);
  endfunction

  // Reference: pixel i of a load lands at (base+i) mod depth; even i is the
  // low half of word i/2, odd i the high half. Pairs are written back to back
  // and done coincides with the final write (or follows start when len=0).
  task automatic expect_load(string tag, logic [AW-1:0] base, int n, int start_cyc);
    void'(chk({tag, " nwrites"}, 32'(wq.size()), 32'(n)));
    for (int i = 0; i < n && i < wq.size(); i++) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic [WW-1:0] w;
      ea = AW'((int'(base) + i) % DEPTH);
      w  = words[i / 2];
      ed = (i % 2 == 1) ? w[WW-1:DW] : w[DW-1:0];
      if (!chk({tag, " addr"}, 32'(wq[i].a), 32'(ea))) break;
      if (!chk({tag, " data"}, 32'(wq[i].d), 32'(ed))) break;
      if (i % 2 == 1)
        if (!chk({tag, " pair_adjacent"}, wq[i].c, wq[i-1].c + 32'd1)) break;
    end
    void'(chk({tag, " done_count"}, 32'(done_cyc.size()), 32'd1));
    if (done_cyc.size() == 1) begin
      if (n == 0)
        void'(chk({tag, " done_timing"}, 32'(done_cyc[0]), 32'(start_cyc + 1)));
      else if (wq.size() == n)
        void'(chk({tag, " done_with_last_we"}, 32'(done_cyc[0]), wq[n-1].c));
    end
  endtask

  task automatic run_load(string tag, logic [AW-1:0] base, logic [AW:0] ln,
                          int stall_pct, bit busy_start);
    int n, nw, idx, cs;
    bit fin;
    n  = (int'(ln) > DEPTH) ? DEPTH : int'(ln);
    nw = (n + 1) / 2;
    while (words.size() < nw) words.push_back(WW'($urandom));
    wq.delete();
    done_cyc.delete();
    @(negedge clk);
    start = 1'b1; base_addr = base; len = ln; s_valid = 1'b0;
    cs = cyc;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    fin = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      if (done === 1'b1) begin
        fin = 1'b1;
        break;
      end
      start = busy_start && (t == 3);
      if (start) begin
        base_addr = ~base;
        len       = 11'd6;
      end
      if (s_ready === 1'b1 && idx < nw) begin
        s_valid = ($urandom_range(99) >= stall_pct);
        s_data  = words[idx];
        if (s_valid) idx++;
      end else begin
        s_valid = 1'($urandom_range(1));
        s_data  = WW'($urandom);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    start   = 1'b0;
    void'(chk({tag, " finished"}, 32'(fin), 32'd1));
    @(negedge clk);
    void'(chk({tag, " idle_busy"}, 32'(busy), 32'd0));
    void'(chk({tag, " idle_we"}, 32'(we), 32'd0));
    expect_load(tag, base, n, cs);
    words.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] w0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; len = '0;
    s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    void'(chk("reset we", 32'(we), 32'd0));
    void'(chk("reset addr_w", 32'(addr_w), 32'd0));
    void'(chk("reset din", 32'(din), 32'd0));
    void'(chk("reset busy", 32'(busy), 32'd0));
    void'(chk("reset done", 32'(done), 32'd0));
    void'(chk("reset s_ready", 32'(s_ready), 32'd0));
    reset_n = 1'b1;

    // Even and odd-with-wrap loads with fixed words
    words = '{24'hBBBAAA, 24'hDDDCCC};
    run_load("even", 10'h010, 11'd4, 0, 1'b0);
    words = '{24'h222111, 24'h444333};
    run_load("odd_wrap", 10'h3FF, 11'd3, 0, 1'b0);

    // Zero-length load
    run_load("len0", 10'h123, 11'd0, 0, 1'b0);

    // Backpressure: five idle cycles in LOAD_LO
    words.delete(); words.push_back(24'h5A5A5A);
    wq.delete(); done_cyc.delete();
    @(negedge clk); start = 1'b1; base_addr = 10'h100; len = 11'd2;
    @(negedge clk); start = 1'b0; s_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      void'(chk("bp s_ready", 32'(s_ready), 32'd1));
      void'(chk("bp we", 32'(we), 32'd0));
      @(negedge clk);
    end
    s_valid = 1'b1; s_data = words[0];
    @(negedge clk); s_valid = 1'b0;
    repeat (2) @(negedge clk);
    void'(chk("bp idle_busy", 32'(busy), 32'd0));
    expect_load("bp", 10'h100, 2, 0);

    // Abort during LOAD_HI of a len=8 load
    wq.delete(); done_cyc.delete();
    w0 = WW'($urandom);
    @(negedge clk); start = 1'b1; base_addr = 10'h200; len = 11'd8;
    @(negedge clk); start = 1'b0;
    void'(chk("abort s_ready_lo", 32'(s_ready), 32'd1));
    s_valid = 1'b1; s_data = w0;
    @(negedge clk);
    void'(chk("abort lo_write", 32'(we), 32'd1));
    void'(chk("abort s_ready_hi", 32'(s_ready), 32'd0));
    abort = 1'b1; s_data = WW'($urandom);
    @(negedge clk); abort = 1'b0; s_valid = 1'b0;
    void'(chk("abort busy", 32'(busy), 32'd0));
    void'(chk("abort we", 32'(we), 32'd0));
    void'(chk("abort done", 32'(done), 32'd0));
    repeat (4) @(negedge clk);
    void'(chk("abort nwrites", 32'(wq.size()), 32'd1));
    if (wq.size() > 0) begin
      void'(chk("abort addr", 32'(wq[0].a), 32'h200));
      void'(chk("abort data", 32'(wq[0].d), 32'(w0[DW-1:0])));
    end
    void'(chk("abort no_done", 32'(done_cyc.size()), 32'd0));

    // Abort in IDLE is ignored; abort beats a simultaneous LOAD_LO transfer
    wq.delete(); done_cyc.delete();
    @(negedge clk); start = 1'b1; abort = 1'b1; base_addr = 10'h300; len = 11'd4;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    void'(chk("idle_abort busy", 32'(busy), 32'd1));
    abort = 1'b1; s_valid = 1'b1; s_data = WW'($urandom);
    @(negedge clk); abort = 1'b0; s_valid = 1'b0;
    void'(chk("abort_prio busy", 32'(busy), 32'd0));
    void'(chk("abort_prio we", 32'(we), 32'd0));
    repeat (2) @(negedge clk);
    void'(chk("abort_prio nwrites", 32'(wq.size()), 32'd0));

    // Reset mid-load, then a normal load from a new base
    @(negedge clk); start = 1'b1; base_addr = 10'h055; len = 11'd4;
    @(negedge clk); start = 1'b0; s_valid = 1'b1; s_data = 24'h987654;
    @(negedge clk); s_valid = 1'b0; reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    void'(chk("rst_mid we", 32'(we), 32'd0));
    void'(chk("rst_mid addr_w", 32'(addr_w), 32'd0));
    void'(chk("rst_mid din", 32'(din), 32'd0));
    void'(chk("rst_mid busy", 32'(busy), 32'd0));
    void'(chk("rst_mid done", 32'(done), 32'd0));
    void'(chk("rst_mid s_ready", 32'(s_ready), 32'd0));
    run_load("post_reset", 10'h2A0, 11'd2, 20, 1'b0);

    // Start while busy must not disturb the running load
    run_load("busy_start", 10'h1C0, 11'd8, 0, 1'b1);

    // Randomized loads, including clamped over-length requests
    for (int r = 0; r < 14; r++) begin
      logic [AW:0] ln;
      case (r)
        5:       ln = 11'd2047;
        6:       ln = 11'd1024;
        7:       ln = 11'd1025;
        default: ln = 11'($urandom_range(0, 40));
      endcase
      words.delete();
      run_load($sformatf("rand%0d", r), AW'($urandom), ln,
               int'($urandom_range(0, 50)), 1'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
